// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB bus arbiter with burst-aware handover
//
// Purpose: shares one AHB subordinate fabric between N_MGR managers. Grants
// change only at legal points: idle cycles, the last beat of a fixed-length
// burst, the end of an INCR burst (owner drops its request), the INCR beat cap
// when another manager is waiting, or the response edge that follows an
// ERROR/RETRY/SPLIT.
//
// Ports:
//   i_hclk       clock
//   i_hreset     synchronous reset, active-high
//   i_hbusreq    per-manager bus request (bit k = manager k)
//   i_htrans     muxed HTRANS of the address-phase owner
//   i_hburst     muxed HBURST of the address-phase owner
//   i_hready     bus HREADY
//   i_hresp      bus HRESP
//   o_hgrant     one-hot registered grant
//   o_hmaster    index of the address-phase owner (address/control mux select)
//   o_hmaster_d  index of the data-phase owner (write/read data mux select)
module ahb_bus_arbiter #(
    parameter int N_MGR       = 4,
    parameter int DEFAULT_MGR = 0,
    parameter int MAX_INCR    = 16
) (
    input  logic                     i_hclk,
    input  logic                     i_hreset,
    input  logic [N_MGR-1:0]         i_hbusreq,
    input  logic [1:0]               i_htrans,
    input  logic [2:0]               i_hburst,
    input  logic                     i_hready,
    input  logic [1:0]               i_hresp,
    output logic [N_MGR-1:0]         o_hgrant,
    output logic [$clog2(N_MGR)-1:0] o_hmaster,
    output logic [$clog2(N_MGR)-1:0] o_hmaster_d
);
    localparam int MW   = $clog2(N_MGR);
    // The counter must reach both the longest fixed burst and the INCR cap.
    localparam int CMAX = (MAX_INCR > 16) ? MAX_INCR : 16;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [1:0] HR_OKAY   = 2'd0;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       len_q, len_d;
    logic             err_pend_q, err_pend_d;
    logic [MW-1:0]    rr_q, rr_d;
    logic [MW-1:0]    hmaster_q, hmaster_d;
    logic [MW-1:0]    data_owner_q, data_owner_d;
    logic [N_MGR-1:0] hgrant_q, hgrant_d;

    logic             accept;
    logic [CW-1:0]    cnt_new;
    logic [4:0]       len_new;
    logic             last_beat;
    logic             owner_req;
    logic             other_req;
    logic             handover;
    logic [MW-1:0]    winner;
    logic [MW-1:0]    scan_idx;
    logic             found;

    // Beats per burst; 0 stands for undefined-length INCR.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst[2:1])
            2'd0:    burst_len = hburst[0] ? 5'd0 : 5'd1;
            2'd1:    burst_len = 5'd4;
            2'd2:    burst_len = 5'd8;
            default: burst_len = 5'd16;
        endcase
    endfunction

    // What the beat tracker would look like if this cycle's beat is accepted.
    always_comb begin
        accept  = i_hready && (i_htrans == HT_NONSEQ || i_htrans == HT_SEQ);
        len_new = (i_htrans == HT_NONSEQ) ? burst_len(i_hburst) : len_q;
        if (i_htrans == HT_NONSEQ) begin
            cnt_new = CW'(1);
        end else if (cnt_q == CW'(CMAX)) begin
            cnt_new = cnt_q;
        end else begin
            cnt_new = cnt_q + CW'(1);
        end
        last_beat = (len_new != 5'd0) && (cnt_new == CW'(len_new));
        owner_req = |(i_hbusreq & hgrant_q);
        other_req = |(i_hbusreq & ~hgrant_q);
    end

    // Round-robin scan starting just after the last winner; the last winner
    // itself is considered last so a lone requester keeps the bus.
    always_comb begin
        winner   = MW'(DEFAULT_MGR);
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= N_MGR; i++) begin
            scan_idx = MW'((int'(rr_q) + i) % N_MGR);
            if (!found && i_hbusreq[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        err_pend_d   = err_pend_q;
        rr_d         = rr_q;
        hmaster_d    = hmaster_q;
        hgrant_d     = hgrant_q;
        data_owner_d = data_owner_q;
        handover     = 1'b0;

        if (i_hready) begin
            data_owner_d = hmaster_q;
            if (err_pend_q) begin
                // Second response cycle: the burst is dead, release the bus.
                err_pend_d = 1'b0;
                cnt_d      = '0;
                len_d      = '0;
                state_d    = ST_IDLE;
                handover   = 1'b1;
            end else begin
                if (i_htrans == HT_IDLE) begin
                    handover = 1'b1;
                end
                if (accept) begin
                    cnt_d   = cnt_new;
                    len_d   = len_new;
                    state_d = last_beat ? ST_IDLE : ST_BURST;
                    if (last_beat) begin
                        handover = 1'b1;
                    end
                    if (len_new == 5'd0 && !owner_req) begin
                        handover = 1'b1;
                    end
                    if (len_new == 5'd0 && cnt_new == CW'(MAX_INCR) && other_req) begin
                        handover = 1'b1;
                    end
                end
            end
        end else if (i_hresp != HR_OKAY) begin
            err_pend_d = 1'b1;
        end

        if (handover) begin
            rr_d             = winner;
            hmaster_d        = winner;
            hgrant_d         = '0;
            hgrant_d[winner] = 1'b1;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            err_pend_q   <= 1'b0;
            rr_q         <= MW'(DEFAULT_MGR);
            hmaster_q    <= MW'(DEFAULT_MGR);
            data_owner_q <= MW'(DEFAULT_MGR);
            hgrant_q     <= {{(N_MGR-1){1'b0}}, 1'b1} << DEFAULT_MGR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            err_pend_q   <= err_pend_d;
            rr_q         <= rr_d;
            hmaster_q    <= hmaster_d;
            data_owner_q <= data_owner_d;
            hgrant_q     <= hgrant_d;
        end
    end

    assign o_hgrant    = hgrant_q;
    assign o_hmaster   = hmaster_q;
    assign o_hmaster_d = data_owner_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - self-checking bench for ahb_bus_arbiter
module tb_ahb_bus_arbiter;
    localparam int N    = 4;
    localparam int MW   = 2;
    localparam int DEF  = 0;
    localparam int MAXI = 16;
    localparam int CMAX = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic          clk = 1'b0;
    logic          hreset;
    logic [N-1:0]  hbusreq;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hready;
    logic [1:0]    hresp;
    logic [N-1:0]  hgrant;
    logic [MW-1:0] hmaster;
    logic [MW-1:0] hmaster_d;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(
        .N_MGR      (N),
        .DEFAULT_MGR(DEF),
        .MAX_INCR   (MAXI)
    ) dut (
        .i_hclk     (clk),
        .i_hreset   (hreset),
        .i_hbusreq  (hbusreq),
        .i_htrans   (htrans),
        .i_hburst   (hburst),
        .i_hready   (hready),
        .i_hresp    (hresp),
        .o_hgrant   (hgrant),
        .o_hmaster  (hmaster),
        .o_hmaster_d(hmaster_d)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, how far into its burst it is.
    int m_owner  = DEF;
    int m_rr     = DEF;
    int m_downer = DEF;
    int m_beats  = 0;
    int m_len    = 0;
    bit m_err    = 1'b0;
    int len_tbl[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    function automatic int pick(input int rr, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            int c = (rr + k) % N;
            if (req[c]) return c;
        end
        return DEF;
    endfunction

    task automatic model_step();
        bit may_switch;
        if (hreset) begin
            m_owner = DEF; m_rr = DEF; m_downer = DEF;
            m_beats = 0; m_len = 0; m_err = 1'b0;
            return;
        end
        if (!hready) begin
            if (hresp != 2'd0) m_err = 1'b1;
            return;
        end
        may_switch = 1'b0;
        m_downer = m_owner;
        if (m_err) begin
            m_err = 1'b0; m_beats = 0; m_len = 0;
            may_switch = 1'b1;
        end else begin
            if (htrans == IDLE) may_switch = 1'b1;
            if (htrans == NONSEQ || htrans == SEQ) begin
                if (htrans == NONSEQ) begin
                    m_len   = len_tbl[hburst];
                    m_beats = 1;
                end else begin
                    m_beats = (m_beats + 1 > CMAX) ? CMAX : m_beats + 1;
                end
                if (m_len != 0 && m_beats == m_len) may_switch = 1'b1;
                if (m_len == 0 && !hbusreq[m_owner]) may_switch = 1'b1;
                if (m_len == 0 && m_beats == MAXI && (hbusreq & ~(N'(1) << m_owner)) != '0)
                    may_switch = 1'b1;
            end
        end
        if (may_switch) begin
            m_owner = pick(m_rr, hbusreq);
            m_rr    = m_owner;
        end
    endtask

    // emd < 0 skips the data-phase owner comparison.
    task automatic chk(input string name, input logic [N-1:0] eg, input int em, input int emd);
        n_tests++;
        if (hgrant !== eg || hmaster !== MW'(em) || (emd >= 0 && hmaster_d !== MW'(emd))) begin
            n_fail++;
            $display("FAIL %s: got grant=%b master=%0d master_d=%0d, want grant=%b master=%0d master_d=%0d",
                     name, hgrant, hmaster, hmaster_d, eg, em, emd);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model", N'(1) << m_owner, m_owner, m_downer);
        n_tests++;
        if (!$onehot(hgrant)) begin
            n_fail++;
            $display("FAIL onehot: got grant=%b, want exactly one bit set", hgrant);
        end
    endtask

    task automatic drive(input bit rst, input logic [N-1:0] req, input logic [1:0] tr,
                         input logic [2:0] bu, input bit rdy, input logic [1:0] rs);
        hreset = rst; hbusreq = req; htrans = tr; hburst = bu; hready = rdy; hresp = rs;
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] req;
        logic [1:0]   tr;
        logic [2:0]   bu;
        bit           rdy;
        logic [N-1:0] g;
        int           m;
        int           md;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input logic [N-1:0] req, input logic [1:0] tr,
                                input logic [2:0] bu, input bit rdy, input logic [N-1:0] g,
                                input int m, input int md);
        vec_t v;
        v.rst = rst; v.req = req; v.tr = tr; v.bu = bu; v.rdy = rdy;
        v.g = g; v.m = m; v.md = md;
        return v;
    endfunction

    initial begin
        drive(1'b1, '0, IDLE, SINGLE, 1'b1, 2'd0);
        tick();
        chk("reset", 4'b0001, 0, 0);
        drive(1'b0, '0, IDLE, SINGLE, 1'b1, 2'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_park", 4'b0001, 0, 0);
        end

        // rotation with all requesting, then mgr1 INCR4 with stalls, then SINGLE
        vecs.push_back(mk(1, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 4'b1111, IDLE,   SINGLE, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b1111, IDLE,   SINGLE, 1, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b1111, IDLE,   SINGLE, 1, 4'b1000, 3, 2));
        vecs.push_back(mk(0, 4'b1111, IDLE,   SINGLE, 1, 4'b0001, 0, 3));
        vecs.push_back(mk(0, 4'b1111, IDLE,   SINGLE, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b0110, NONSEQ, INCR4,  1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0110, SEQ,    INCR4,  0, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0110, SEQ,    INCR4,  1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0110, SEQ,    INCR4,  0, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0110, SEQ,    INCR4,  1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0110, SEQ,    INCR4,  1, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0100, IDLE,   SINGLE, 0, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0100, IDLE,   SINGLE, 1, 4'b0100, 2, 2));
        vecs.push_back(mk(0, 4'b0001, NONSEQ, SINGLE, 1, 4'b0001, 0, 2));
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].tr, vecs[i].bu, vecs[i].rdy, 2'd0);
            tick();
            chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].m, vecs[i].md);
        end

        // INCR beat cap with a competing request
        drive(0, 4'b0100, IDLE, SINGLE, 1, 2'd0); tick(); chk("to_mgr2", 4'b0100, 2, -1);
        drive(0, 4'b1100, NONSEQ, INCR, 1, 2'd0); tick();
        for (int b = 2; b <= 15; b++) begin
            drive(0, 4'b1100, SEQ, INCR, 1, 2'd0); tick();
        end
        chk("incr_beat15", 4'b0100, 2, -1);
        drive(0, 4'b1100, SEQ, INCR, 1, 2'd0); tick(); chk("incr_cap16", 4'b1000, 3, -1);

        // INCR past the cap with no competitor
        drive(0, 4'b0100, IDLE, SINGLE, 1, 2'd0); tick(); chk("back_mgr2", 4'b0100, 2, -1);
        drive(0, 4'b0100, NONSEQ, INCR, 1, 2'd0); tick();
        for (int b = 2; b <= 20; b++) begin
            drive(0, 4'b0100, SEQ, INCR, 1, 2'd0); tick();
        end
        chk("incr_nocap", 4'b0100, 2, -1);
        drive(0, 4'b0000, IDLE, SINGLE, 1, 2'd0); tick(); chk("park_default", 4'b0001, 0, -1);

        // two-cycle ERROR in mgr0 INCR8 at beat 3
        drive(0, 4'b1001, NONSEQ, INCR8, 1, 2'd0); tick();
        drive(0, 4'b1001, SEQ, INCR8, 1, 2'd0); tick();
        drive(0, 4'b1001, SEQ, INCR8, 1, 2'd0); tick(); chk("err_beat3", 4'b0001, 0, -1);
        drive(0, 4'b1001, SEQ, INCR8, 0, 2'd1); tick(); chk("err_first", 4'b0001, 0, -1);
        drive(0, 4'b1001, SEQ, INCR8, 1, 2'd1); tick(); chk("err_handover", 4'b1000, 3, -1);

        // reset in the middle of mgr2 INCR16
        drive(0, 4'b0100, IDLE, SINGLE, 1, 2'd0); tick(); chk("to_mgr2_b", 4'b0100, 2, -1);
        drive(0, 4'b0100, NONSEQ, INCR16, 1, 2'd0); tick();
        for (int b = 0; b < 3; b++) begin
            drive(0, 4'b0100, SEQ, INCR16, 1, 2'd0); tick();
        end
        drive(1, 4'b0100, SEQ, INCR16, 1, 2'd0); tick(); chk("reset_mid", 4'b0001, 0, 0);
        drive(0, 4'b0011, NONSEQ, INCR4, 1, 2'd0); tick();
        drive(0, 4'b0011, SEQ, INCR4, 1, 2'd0); tick();
        drive(0, 4'b0011, SEQ, INCR4, 1, 2'd0); tick(); chk("post_reset_b3", 4'b0001, 0, -1);
        drive(0, 4'b0011, SEQ, INCR4, 1, 2'd0); tick(); chk("post_reset_b4", 4'b0010, 1, -1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rs;
            rs = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            drive($urandom_range(0, 99) == 0, N'($urandom), 2'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0, rs);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
